// File: rtl/fft_peak_reader_if.sv
// Bundle between the FFT peak reader and its RAM / wrapper / result consumer.
// thresh and peak_found exist only when FFT_PEAK_THRESH_EN is defined.
interface fft_peak_reader_if;
  logic        fftdone;
  logic [27:0] ram_q;
  logic [9:0]  rd_addr_fft;
  logic        go;
  logic        result_valid;
  logic        result_ack;
  logic [9:0]  peak_bin;
  logic [27:0] peak_mag;
  logic        busy;
`ifdef FFT_PEAK_THRESH_EN
  logic [27:0] thresh;
  logic        peak_found;
`endif

  modport master (
    input  fftdone, ram_q, result_ack,
`ifdef FFT_PEAK_THRESH_EN
    input  thresh,
    output peak_found,
`endif
    output rd_addr_fft, go, result_valid, peak_bin, peak_mag, busy
  );

  modport slave (
    output fftdone, ram_q, result_ack,
`ifdef FFT_PEAK_THRESH_EN
    output thresh,
    input  peak_found,
`endif
    input  rd_addr_fft, go, result_valid, peak_bin, peak_mag, busy
  );
endinterface

// File: rtl/fft_peak_reader.sv
// Sweeps the FFT result RAM after fftdone, keeps the strongest |X|^2 bin, offers it on valid/ack, then pulses go.
// Optional FFT_PEAK_THRESH_EN adds a thresh input and a peak_found flag latched with the result.
module fft_peak_reader #(
  parameter logic [9:0] BIN_LO = 10'd1,
  parameter logic [9:0] BIN_HI = 10'd511,
  parameter int          RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_peak_reader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SWEEP, S_DRAIN, S_HOLD, S_RELEASE, S_WAITLOW
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(RD_LAT + 1);

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic        start_frame;
  logic        latch_result;

  // Tag pipeline: bin index travelling alongside the RAM read latency.
  logic [RD_LAT-1:0] tag_vld_q;
  logic [9:0]        tag_q [RD_LAT];

  logic              a_vld_q;
  logic [9:0]        a_bin_q;
  logic [26:0]       a_re2_q, a_im2_q;
  logic [27:0]       max_mag_q;
  logic [9:0]        max_bin_q;
  logic [9:0]        peak_bin_q;
  logic [27:0]       peak_mag_q;
`ifdef FFT_PEAK_THRESH_EN
  logic              peak_found_q;
`endif

  logic signed [13:0] re_s, im_s;
  logic signed [26:0] re_x, im_x;
  logic [26:0]        re2, im2;
  logic [27:0]        sum_b;

  assign re_s  = bus.ram_q[27:14];
  assign im_s  = bus.ram_q[13:0];
  assign re_x  = {{13{re_s[13]}}, re_s};
  assign im_x  = {{13{im_s[13]}}, im_s};
  // (-8192)^2 = 2^26 lands exactly in bit 26 of the 27-bit product.
  assign re2   = re_x * re_x;
  assign im2   = im_x * im_x;
  assign sum_b = {1'b0, a_re2_q} + {1'b0, a_im2_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= BIN_LO;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    drain_cnt_d  = drain_cnt_q;
    start_frame  = 1'b0;
    latch_result = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.fftdone) begin
          state_d     = S_SWEEP;
          addr_d      = BIN_LO;
          start_frame = 1'b1;
        end
      end
      S_SWEEP: begin
        if (addr_q == BIN_HI) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else begin
          addr_d = 10'(addr_q + 10'd1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          latch_result = 1'b1;
          state_d      = S_HOLD;
        end else begin
          drain_cnt_d = 3'(drain_cnt_q + 3'd1);
        end
      end
      S_HOLD: begin
        if (bus.result_ack) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_WAITLOW;
      S_WAITLOW: begin
        // The wrapper may keep fftdone high briefly after go; never re-read that frame.
        if (!bus.fftdone) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      a_vld_q    <= 1'b0;
      a_bin_q    <= '0;
      a_re2_q    <= '0;
      a_im2_q    <= '0;
      max_mag_q  <= '0;
      max_bin_q  <= BIN_LO;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
`ifdef FFT_PEAK_THRESH_EN
      peak_found_q <= 1'b0;
`endif
    end else begin
      tag_vld_q[0] <= (state_q == S_SWEEP);
      tag_q[0]     <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_q[i]     <= tag_q[i-1];
      end

      a_vld_q <= tag_vld_q[RD_LAT-1];
      a_bin_q <= tag_q[RD_LAT-1];
      a_re2_q <= re2;
      a_im2_q <= im2;

      // Strictly-greater update keeps the lowest bin on ties.
      if (start_frame) begin
        max_mag_q <= '0;
        max_bin_q <= BIN_LO;
      end else if (a_vld_q && (sum_b > max_mag_q)) begin
        max_mag_q <= sum_b;
        max_bin_q <= a_bin_q;
      end

      if (latch_result) begin
        peak_bin_q <= max_bin_q;
        peak_mag_q <= max_mag_q;
`ifdef FFT_PEAK_THRESH_EN
        peak_found_q <= (max_mag_q >= bus.thresh);
`endif
      end
    end
  end

  assign bus.rd_addr_fft  = addr_q;
  assign bus.go           = (state_q == S_RELEASE);
  assign bus.result_valid = (state_q == S_HOLD);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.peak_bin     = peak_bin_q;
  assign bus.peak_mag     = peak_mag_q;
`ifdef FFT_PEAK_THRESH_EN
  assign bus.peak_found   = peak_found_q;
`endif

endmodule

// File: tb/tb_fft_peak_reader.sv
// Bench for fft_peak_reader: a default instance and a single-bin instance (BIN 5, RD_LAT 3), each fed by a latency-matched RAM model.
module tb_fft_peak_reader;
  localparam logic [9:0] LO0 = 10'd1, HI0 = 10'd511;
  localparam int         LAT0 = 2;
  localparam logic [9:0] LO1 = 10'd5, HI1 = 10'd5;
  localparam int         LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [27:0] mem0 [1024];
  logic [27:0] mem1 [1024];
  logic [27:0] q0 [LAT0];
  logic [27:0] q1 [LAT1];

  fft_peak_reader_if if0 ();
  fft_peak_reader_if if1 ();

  fft_peak_reader #(.BIN_LO(LO0), .BIN_HI(HI0), .RD_LAT(LAT0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  fft_peak_reader #(.BIN_LO(LO1), .BIN_HI(HI1), .RD_LAT(LAT1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q0[0] <= mem0[if0.rd_addr_fft];
    for (int i = 1; i < LAT0; i++) q0[i] <= q0[i-1];
    q1[0] <= mem1[if1.rd_addr_fft];
    for (int i = 1; i < LAT1; i++) q1[i] <= q1[i-1];
  end
  assign if0.ram_q = q0[LAT0-1];
  assign if1.ram_q = q1[LAT1-1];

  function automatic logic rv(input int s);          return (s != 0) ? if1.result_valid : if0.result_valid; endfunction
  function automatic logic go_o(input int s);        return (s != 0) ? if1.go : if0.go; endfunction
  function automatic logic busy_o(input int s);      return (s != 0) ? if1.busy : if0.busy; endfunction
  function automatic logic [9:0] addr_o(input int s); return (s != 0) ? if1.rd_addr_fft : if0.rd_addr_fft; endfunction
  function automatic logic [9:0] bin_o(input int s);  return (s != 0) ? if1.peak_bin : if0.peak_bin; endfunction
  function automatic logic [27:0] mag_o(input int s); return (s != 0) ? if1.peak_mag : if0.peak_mag; endfunction
  function automatic int lo_of(input int s);          return (s != 0) ? int'(LO1) : int'(LO0); endfunction
  function automatic int hi_of(input int s);          return (s != 0) ? int'(HI1) : int'(HI0); endfunction
  function automatic int lat_of(input int s);         return (s != 0) ? LAT1 : LAT0; endfunction

  task automatic set_done(input int s, input logic v);
    if (s != 0) if1.fftdone = v; else if0.fftdone = v;
  endtask
  task automatic set_ack(input int s, input logic v);
    if (s != 0) if1.result_ack = v; else if0.result_ack = v;
  endtask

  function automatic logic [27:0] mk(input int re, input int im);
    logic [13:0] r, i;
    r = 14'(re);
    i = 14'(im);
    return {r, i};
  endfunction

  function automatic longint mag_of(input logic [27:0] w);
    int re, im;
    re = int'($signed(w[27:14]));
    im = int'($signed(w[13:0]));
    return longint'(re) * re + longint'(im) * im;
  endfunction

  task automatic put(input int s, input int b, input logic [27:0] w);
    if (s != 0) mem1[b] = w; else mem0[b] = w;
  endtask

  task automatic clear_mem(input int s);
    for (int b = 0; b < 1024; b++) put(s, b, 28'd0);
  endtask

  task automatic rand_frame(input int s);
    int amp, re, im, b1, b2;
    amp = int'($urandom_range(1, 8192));
    for (int b = 0; b < 1024; b++) begin
      re = int'($urandom_range(0, 2 * amp)) - amp;
      im = int'($urandom_range(0, 2 * amp)) - amp;
      if (re > 8191) re = 8191;
      if (im > 8191) im = 8191;
      put(s, b, mk(re, im));
    end
    if ((s == 0) && ($urandom_range(0, 1) == 1)) begin
      b1 = int'($urandom_range(1, 255));
      b2 = b1 + int'($urandom_range(1, 255));
      put(s, b1, mk(-8192, int'($urandom_range(0, 100)) - 50));
      put(s, b2, s == 0 ? mem0[b1] : mem1[b1]);
    end
    // Bin 0 is the largest of all; it must stay outside the default window.
    if (s == 0) put(s, 0, mk(-8192, -8192));
  endtask

  // Argmax over the window, first (lowest) bin wins ties.
  task automatic ref_peak(input int s, output int bin, output longint mag);
    longint m;
    bin = lo_of(s);
    mag = 0;
    for (int b = lo_of(s); b <= hi_of(s); b++) begin
      m = mag_of(s != 0 ? mem1[b] : mem0[b]);
      if (m > mag) begin mag = m; bin = b; end
    end
  endtask

  task automatic wait_valid(input int s, output int cyc, output int incr, output int outside);
    logic [9:0] prev, a;
    prev = addr_o(s);
    cyc = 0; incr = 0; outside = 0;
    while (!rv(s) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      a = addr_o(s);
      if (a == 10'(prev + 10'd1)) incr++;
      if (int'(a) < lo_of(s) || int'(a) > hi_of(s)) outside++;
      prev = a;
    end
  endtask

  task automatic do_ack(input int s, input int extra_hi, output int n_go, output bit moved,
                        output bit busy_mid, output bit busy_end);
    logic [9:0] a0;
    set_ack(s, 1'b1);
    @(negedge clk);
    set_ack(s, 1'b0);
    a0 = addr_o(s);
    n_go = 0; moved = 0; busy_mid = 0;
    for (int i = 0; i < extra_hi + 12; i++) begin
      if (go_o(s)) n_go++;
      if (i == 1) busy_mid = busy_o(s);
      if (i == extra_hi) set_done(s, 1'b0);
      if (addr_o(s) !== a0) moved = 1;
      @(negedge clk);
    end
    busy_end = busy_o(s);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (addr_o(s) !== 10'(lo_of(s))) begin n_bad++; $display("FAIL reset_addr dut%0d: got %0d want %0d", s, addr_o(s), lo_of(s)); end
      n_cmp++; if (go_o(s) !== 1'b0) begin n_bad++; $display("FAIL reset_go dut%0d: got %b want 0", s, go_o(s)); end
      n_cmp++; if (rv(s) !== 1'b0) begin n_bad++; $display("FAIL reset_valid dut%0d: got %b want 0", s, rv(s)); end
      n_cmp++; if (bin_o(s) !== 10'd0) begin n_bad++; $display("FAIL reset_bin dut%0d: got %0d want 0", s, bin_o(s)); end
      n_cmp++; if (mag_o(s) !== 28'd0) begin n_bad++; $display("FAIL reset_mag dut%0d: got %0d want 0", s, mag_o(s)); end
      n_cmp++; if (busy_o(s) !== 1'b0) begin n_bad++; $display("FAIL reset_busy dut%0d: got %b want 0", s, busy_o(s)); end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy_o(0) !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy_o(0)); end
  endtask

  task automatic test_single_peak();
    int cyc, incr, outside, n_go, rb;
    bit moved, bm, be;
    longint rm;
    clear_mem(0);
    put(0, 37, mk(1000, -500));
    ref_peak(0, rb, rm);
    set_done(0, 1'b1);
    wait_valid(0, cyc, incr, outside);
    n_cmp++; if (cyc != 516) begin n_bad++; $display("FAIL single_latency: got %0d want 516", cyc); end
    n_cmp++; if (incr != 510 || outside != 0) begin n_bad++; $display("FAIL single_sweep: incr %0d outside %0d want 510/0", incr, outside); end
    n_cmp++; if (bin_o(0) !== 10'd37) begin n_bad++; $display("FAIL single_bin: got %0d want 37", bin_o(0)); end
    n_cmp++; if (mag_o(0) !== 28'd1250000) begin n_bad++; $display("FAIL single_mag: got %0d want 1250000", mag_o(0)); end
    n_cmp++; if (int'(bin_o(0)) != rb || longint'(mag_o(0)) != rm) begin n_bad++; $display("FAIL single_model: got %0d/%0d want %0d/%0d", bin_o(0), mag_o(0), rb, rm); end
    do_ack(0, 2, n_go, moved, bm, be);
    n_cmp++; if (n_go != 1) begin n_bad++; $display("FAIL single_go: got %0d pulses want 1", n_go); end
    n_cmp++; if (moved || be) begin n_bad++; $display("FAIL single_release: moved %0d busy %0d want 0/0", moved, be); end
  endtask

  task automatic test_tie_overflow();
    int cyc, incr, outside, n_go;
    bit moved, bm, be;
    clear_mem(0);
    put(0, 0, mk(-8192, -8192));
    put(0, 100, mk(-8192, -8192));
    put(0, 200, mk(-8192, -8192));
    set_done(0, 1'b1);
    wait_valid(0, cyc, incr, outside);
    n_cmp++; if (bin_o(0) !== 10'd100) begin n_bad++; $display("FAIL tie_bin: got %0d want 100", bin_o(0)); end
    n_cmp++; if (mag_o(0) !== 28'd134217728) begin n_bad++; $display("FAIL tie_mag: got %0d want 134217728", mag_o(0)); end
    do_ack(0, 0, n_go, moved, bm, be);
    n_cmp++; if (n_go != 1 || be) begin n_bad++; $display("FAIL tie_release: go %0d busy %0d want 1/0", n_go, be); end
  endtask

  task automatic test_hold_stable();
    int cyc, incr, outside, n_go, rb, unstable;
    bit moved, bm, be;
    longint rm;
    logic [9:0] hb;
    logic [27:0] hm;
    rand_frame(0);
    ref_peak(0, rb, rm);
    set_done(0, 1'b1);
    wait_valid(0, cyc, incr, outside);
    n_cmp++; if (int'(bin_o(0)) != rb || longint'(mag_o(0)) != rm) begin n_bad++; $display("FAIL hold_model: got %0d/%0d want %0d/%0d", bin_o(0), mag_o(0), rb, rm); end
    hb = bin_o(0); hm = mag_o(0); unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!rv(0) || go_o(0) || bin_o(0) !== hb || mag_o(0) !== hm) unstable++;
    end
    n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable); end
    do_ack(0, 2, n_go, moved, bm, be);
    n_cmp++; if (n_go != 1) begin n_bad++; $display("FAIL hold_go: got %0d pulses want 1", n_go); end
    n_cmp++; if (!bm || moved) begin n_bad++; $display("FAIL hold_waitlow: busy_mid %0d moved %0d want 1/0", bm, moved); end
    n_cmp++; if (be) begin n_bad++; $display("FAIL hold_busy_end: got %0d want 0", be); end
  endtask

  task automatic test_random_frames();
    int cyc, incr, outside, n_go, rb, k;
    bit moved, bm, be;
    longint rm;
    for (int f = 0; f < 4; f++) begin
      rand_frame(0);
      ref_peak(0, rb, rm);
      if (f == 2) set_ack(0, 1'b1);
      set_done(0, 1'b1);
      k = 0;
      if (f == 1) begin
        k = int'($urandom_range(10, 400));
        repeat (k) @(negedge clk);
        set_done(0, 1'b0);
      end
      wait_valid(0, cyc, incr, outside);
      n_cmp++; if (cyc + k != 516) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want 516", f, cyc + k); end
      n_cmp++; if (int'(bin_o(0)) != rb || longint'(mag_o(0)) != rm) begin n_bad++; $display("FAIL rand%0d_peak: got %0d/%0d want %0d/%0d", f, bin_o(0), mag_o(0), rb, rm); end
      if (f == 2) begin
        @(negedge clk);
        n_cmp++; if (rv(0) !== 1'b0 || go_o(0) !== 1'b1) begin n_bad++; $display("FAIL preack_onecycle: valid %b go %b want 0/1", rv(0), go_o(0)); end
        set_ack(0, 1'b0);
        set_done(0, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++; if (busy_o(0) !== 1'b0) begin n_bad++; $display("FAIL preack_busy: got %b want 0", busy_o(0)); end
      end else begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        do_ack(0, int'($urandom_range(0, 3)), n_go, moved, bm, be);
        n_cmp++; if (n_go != 1 || be) begin n_bad++; $display("FAIL rand%0d_release: go %0d busy %0d want 1/0", f, n_go, be); end
      end
    end
  endtask

  task automatic test_single_bin();
    int cyc, incr, outside, n_go, rb;
    bit moved, bm, be;
    longint rm;
    clear_mem(1);
    put(1, 4, mk(8191, 8191));
    put(1, 6, mk(-8192, 100));
    set_done(1, 1'b1);
    wait_valid(1, cyc, incr, outside);
    n_cmp++; if (cyc != 1 + 1 + LAT1 + 2) begin n_bad++; $display("FAIL one_latency: got %0d want %0d", cyc, 1 + 1 + LAT1 + 2); end
    n_cmp++; if (outside != 0 || addr_o(1) !== 10'd5) begin n_bad++; $display("FAIL one_addr: outside %0d addr %0d want 0/5", outside, addr_o(1)); end
    n_cmp++; if (bin_o(1) !== 10'd5 || mag_o(1) !== 28'd0) begin n_bad++; $display("FAIL one_zero: got %0d/%0d want 5/0", bin_o(1), mag_o(1)); end
    do_ack(1, 1, n_go, moved, bm, be);
    n_cmp++; if (n_go != 1 || be) begin n_bad++; $display("FAIL one_release: go %0d busy %0d want 1/0", n_go, be); end
    put(1, 5, mk(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192));
    ref_peak(1, rb, rm);
    set_done(1, 1'b1);
    wait_valid(1, cyc, incr, outside);
    n_cmp++; if (int'(bin_o(1)) != rb || longint'(mag_o(1)) != rm) begin n_bad++; $display("FAIL one_rand: got %0d/%0d want %0d/%0d", bin_o(1), mag_o(1), rb, rm); end
    do_ack(1, 0, n_go, moved, bm, be);
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, incr, outside, n_go, rb, guard, gos;
    bit moved, bm, be;
    longint rm;
    rand_frame(0);
    ref_peak(0, rb, rm);
    set_done(0, 1'b1);
    guard = 0;
    while (addr_o(0) !== 10'd300 && guard < 1000) begin @(negedge clk); guard++; end
    n_cmp++; if (addr_o(0) !== 10'd300) begin n_bad++; $display("FAIL midrst_reach: got %0d want 300", addr_o(0)); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (addr_o(0) !== LO0 || busy_o(0) !== 1'b0 || rv(0) !== 1'b0 || go_o(0) !== 1'b0)
      begin n_bad++; $display("FAIL midrst_async: addr %0d busy %b valid %b go %b want 1/0/0/0", addr_o(0), busy_o(0), rv(0), go_o(0)); end
    n_cmp++; if (bin_o(0) !== 10'd0 || mag_o(0) !== 28'd0) begin n_bad++; $display("FAIL midrst_result: got %0d/%0d want 0/0", bin_o(0), mag_o(0)); end
    gos = 0;
    repeat (3) begin @(negedge clk); if (go_o(0)) gos++; end
    rst_n = 1'b1;
    wait_valid(0, cyc, incr, outside);
    n_cmp++; if (gos != 0 || cyc != 516 || incr != 510) begin n_bad++; $display("FAIL midrst_resweep: go %0d lat %0d incr %0d want 0/516/510", gos, cyc, incr); end
    n_cmp++; if (int'(bin_o(0)) != rb || longint'(mag_o(0)) != rm) begin n_bad++; $display("FAIL midrst_peak: got %0d/%0d want %0d/%0d", bin_o(0), mag_o(0), rb, rm); end
    do_ack(0, 2, n_go, moved, bm, be);
    n_cmp++; if (n_go != 1 || be) begin n_bad++; $display("FAIL midrst_release: go %0d busy %0d want 1/0", n_go, be); end
  endtask

`ifdef FFT_PEAK_THRESH_EN
  task automatic test_thresh();
    int cyc, incr, outside, n_go;
    bit moved, bm, be;
    clear_mem(0);
    put(0, 37, mk(1000, -500));
    for (int t = 0; t < 2; t++) begin
      if0.thresh = (t == 0) ? 28'd1250001 : 28'd1250000;
      set_done(0, 1'b1);
      wait_valid(0, cyc, incr, outside);
      n_cmp++; if (if0.peak_found !== (t == 1)) begin n_bad++; $display("FAIL thresh%0d_found: got %b want %0d", t, if0.peak_found, t); end
      n_cmp++; if (bin_o(0) !== 10'd37 || mag_o(0) !== 28'd1250000) begin n_bad++; $display("FAIL thresh%0d_peak: got %0d/%0d want 37/1250000", t, bin_o(0), mag_o(0)); end
      do_ack(0, 0, n_go, moved, bm, be);
    end
  endtask
`endif

  initial begin
    if0.fftdone = 1'b0; if0.result_ack = 1'b0;
    if1.fftdone = 1'b0; if1.result_ack = 1'b0;
`ifdef FFT_PEAK_THRESH_EN
    if0.thresh = '0; if1.thresh = '0;
`endif
    clear_mem(0);
    clear_mem(1);
    repeat (2) @(negedge clk);
    test_reset();
    test_single_peak();
    test_tie_overflow();
    test_hold_stable();
    test_random_frames();
    test_single_bin();
    test_reset_mid_sweep();
`ifdef FFT_PEAK_THRESH_EN
    test_thresh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
